// File: rtl/rs232in_fifo_pkg.sv
// Shared rs232 receive-path constants; the peripheral status register sizes
// its count field from the same FIFO depth.
package rs232in_fifo_pkg;
   localparam int RS232_RX_FIFO_DEPTH = 16;
   localparam int RS232_BYTE_W        = 8;

   typedef logic [RS232_BYTE_W-1:0] rs232_byte_t;
endpackage

// File: rtl/rs232in_fifo_ram.sv
// Byte storage behind the FIFO head register: 2**AW-1 slots, one write port,
// one read port with data registered one cycle after the address, no reset.
module fifo_ram #(
   parameter int AW = 4,
   parameter int W  = 8
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);
   localparam int SLOTS = (1 << AW) - 1;

   logic [W-1:0] mem_q [SLOTS];
   logic [W-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (we) mem_q[wr_addr] <= wr_data;
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/rs232in_fifo.sv
// Show-ahead receive FIFO: registered head byte plus a circular RAM of
// DEPTH-1 slots, with fill count and sticky overflow.
module rs232in_fifo
   import rs232in_fifo_pkg::*;
#(
   parameter int DEPTH = RS232_RX_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        rst_n,
   input  rs232_byte_t in_data,
   input  logic        in_valid,
   input  logic        rd,
   output rs232_byte_t rd_data,
   output logic        rd_valid,
   output logic [AW:0] count,
   output logic        overflow,
   input  logic        clr_overflow,
   input  logic        flush
);
   localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE       = (AW+1)'(1);
   localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 2);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_HEAD  = 2'd1;
   localparam logic [1:0] ST_BUF   = 2'd2;

   rs232_byte_t   rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic          byp_valid_q, byp_valid_d;
   rs232_byte_t   byp_data_q, byp_data_d;

   logic [1:0]  state;
   logic        push, pop, drop, full, ram_we;
   rs232_byte_t ram_rdata, ram_front;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      state = ST_BUF;
      if (count_q == '0)      state = ST_EMPTY;
      else if (count_q == ONE) state = ST_HEAD;
   end

   always_comb begin
      full      = (count_q == FULL);
      pop       = rd & rd_valid_q & ~flush;
      push      = in_valid & ~flush & (~full | pop);
      drop      = in_valid & ~flush & full & ~pop;
      // A slot written on the same edge its read address is latched reads stale data
      ram_front = byp_valid_q ? byp_data_q : ram_rdata;

      rd_data_d = rd_data_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      ram_we    = 1'b0;
      count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

      if (flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         case (state)
            ST_EMPTY: if (push) rd_data_d = in_data;
            ST_HEAD: begin
               if (pop) begin
                  if (push) rd_data_d = in_data;
               end else begin
                  ram_we = push;
               end
            end
            default: begin
               if (pop) begin
                  rd_data_d = ram_front;
                  rd_ptr_d  = ptr_inc(rd_ptr_q);
               end
               ram_we = push;
            end
         endcase
      end

      if (ram_we) wr_ptr_d = ptr_inc(wr_ptr_q);

      byp_valid_d = ram_we & (wr_ptr_q == rd_ptr_d);
      byp_data_d  = in_data;
      rd_valid_d  = (count_d != '0);

      overflow_d = overflow_q;
      if (drop)              overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         byp_valid_q <= 1'b0;
         byp_data_q  <= '0;
      end else begin
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         byp_valid_q <= byp_valid_d;
         byp_data_q  <= byp_data_d;
      end
   end

   // RAM read address tracks the next pointer so the front is ready the cycle it is needed
   fifo_ram #(
      .AW (AW),
      .W  (RS232_BYTE_W)
   ) u_ram (
      .clock   (clock),
      .we      (ram_we),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_d),
      .rd_data (ram_rdata)
   );

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign count    = count_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_rs232in_fifo.sv
// Directed and random stimulus for rs232in_fifo against a queue scoreboard.
module tb_rs232in_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clock = 1'b0;
   logic          rst_n;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          rd;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic [AW:0]   count;
   logic          overflow;
   logic          clr_overflow;
   logic          flush;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic [7:0] sb[$];
   logic       ovf_m = 1'b0;

   rs232in_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .rd           (rd),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .flush        (flush)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "/count"}, 32'(count), 32'(sb.size()));
      check({tag, "/rd_valid"}, 32'(rd_valid), 32'(sb.size() != 0));
      check({tag, "/overflow"}, 32'(overflow), 32'(ovf_m));
      if (sb.size() != 0) check({tag, "/head"}, 32'(rd_data), 32'(sb[0]));
   endtask

   // One clock: drive inputs, update the scoreboard, then check after the edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                        input logic f, input logic c, input string tag);
      logic pop_m, push_m, full_m;
      in_valid = v; in_data = d; rd = r; flush = f; clr_overflow = c;
      full_m = (sb.size() == DEPTH);
      pop_m  = r && (sb.size() != 0) && !f;
      push_m = v && !f && (!full_m || pop_m);
      if (pop_m) begin
         check({tag, "/pop_data"}, 32'(rd_data), 32'(sb[0]));
         void'(sb.pop_front());
      end
      if (f) sb.delete();
      if (push_m) sb.push_back(d);
      if (v && !f && full_m && !pop_m) ovf_m = 1'b1;
      else if (c)                      ovf_m = 1'b0;
      @(posedge clock); #1;
      in_valid = 1'b0; rd = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
      check_state(tag);
   endtask

   task automatic drain(input string tag);
      while (sb.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, tag);
   endtask

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; rd = 1'b0;
      clr_overflow = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset/rd_data", 32'(rd_data), 32'h0);
      check("reset/rd_valid", 32'(rd_valid), 32'h0);
      check("reset/count", 32'(count), 32'h0);
      check("reset/overflow", 32'(overflow), 32'h0);
      #3 rst_n = 1'b1;
      @(posedge clock); #1;

      // single push, one-cycle visibility, then pop
      repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "t1_push");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t1_hold");
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t1_pop");
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "t1_pop_empty");

      // fill to DEPTH, drop one, drain back-to-back
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "t2_fill");
      cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, "t2_drop");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t2_clr");
      drain("t2_drain");

      // full with simultaneous push+pop, pointers wrap
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, "t3_fill");
      cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "t3_pushpop_full");
      drain("t3_drain");

      // push+pop at count 1 and count 3
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "t4_push");
      cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, "t4_pp1");
      cycle(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, "t4_push");
      cycle(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, "t4_pp2");
      cycle(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, "t4_push");
      cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, "t4_pp3");
      cycle(1'b1, 8'h34, 1'b1, 1'b0, 1'b0, "t4_pp3");
      drain("t4_drain");

      // flush beats push and pop
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, "t5_fill");
      cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, "t5_flush");
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "t5_push");
      drain("t5_drain");

      // overflow set wins over clear; clear alone
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, "t6_fill");
      cycle(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, "t6_set_vs_clr");
      cycle(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0, "t6_flush_keeps_ovf");
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t6_clr");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0), "rand");
      end

      // asynchronous reset mid-burst
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, "t6_burst");
      for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0, "t6_burst_ovf");
      #2 rst_n = 1'b0;
      #1;
      check("areset/rd_data", 32'(rd_data), 32'h0);
      check("areset/rd_valid", 32'(rd_valid), 32'h0);
      check("areset/count", 32'(count), 32'h0);
      check("areset/overflow", 32'(overflow), 32'h0);
      sb.delete();
      ovf_m = 1'b0;
      @(posedge clock); #3 rst_n = 1'b1;
      @(posedge clock); #1;
      cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, "post_reset_push");
      drain("post_reset_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rs232in_fifo.md
Name: rs232in_fifo

Overview:
- Receive-side byte buffer between the serial receiver (8-bit data plus one-cycle attention strobe) and the rs232 peripheral register block.
- Absorbs bursts at 230400 bps so the CPU does not lose bytes while it is stalled on memory.
- Presents a show-ahead (first-word-fall-through) head byte with a pop handshake.
- Reports fill level and a sticky overflow flag.

Parameters:
- DEPTH, 16, total byte capacity including the head register; power of two, 2 to 256.
- AW, 4, log2(DEPTH); `count` is AW+1 bits wide.

Ports:
- clock  in  1  system clock (same domain as the CPU).
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  received byte; valid only when in_valid=1.
- in_valid  in  1  one-cycle push strobe (receiver attention).
- rd  in  1  pop request; honoured only when rd_valid=1.
- rd_data  out  8  head byte; registered output.
- rd_valid  out  1  FIFO non-empty; rd_data is meaningful.
- count  out  AW+1  bytes held, 0..DEPTH.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.
- flush  in  1  synchronous discard of all contents.

Behaviour:
- Reset, asynchronous on rst_n low: rd_data=0, rd_valid=0, count=0, overflow=0, read/write pointers=0. RAM contents are don't-care. Reset mid-burst loses all data; the first push after release behaves as a push into an empty FIFO.
- Storage:
  - Head register (rd_data) plus a DEPTH-1 entry circular RAM with AW-bit pointers that wrap modulo DEPTH-1 storage slots.
  - Pointer wrap must be exercised; pointer-equality ambiguity is resolved by `count`, not by an extra pointer bit.
- Effective events each cycle:
  - push = in_valid & ~flush & (count<DEPTH | pop)
  - pop = rd & rd_valid & ~flush
- Latency:
  - Push into an empty FIFO at edge N bypasses the RAM: rd_data=in_data and rd_valid=1 after edge N, i.e. visible in cycle N+1.
  - After a pop, the next byte, if any, is in rd_data the following cycle. There are no bubbles: back-to-back pops every cycle drain one byte per cycle.
- Count: count_next = count + push - pop.
- Simultaneous push and pop:
  - count=1: the new byte becomes head; count stays 1.
  - count>1: head takes the RAM front; the new byte is appended.
  - count=DEPTH: the push is accepted (no overflow); count stays DEPTH.
- Full: in_valid with count=DEPTH and no pop drops the byte, sets overflow, and leaves contents and count unchanged.
- Empty: rd with rd_valid=0 is ignored. rd_data holds its last value (not required to be 0).
- Flush:
  - Next cycle: count=0, rd_valid=0, pointers equal.
  - flush has priority over in_valid and rd; the dropped push does not set overflow.
  - flush does not clear overflow.
- Overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Otherwise clr_overflow clears it on the next edge.
- count and rd_valid are registered and mutually consistent every cycle: rd_valid = (count!=0).
- No combinational path from any input to any output.

Decomposition:
- Shared header (next to the pipe-connect definitions): RS232_RX_FIFO_DEPTH default and the byte width constant (8). The rs232 peripheral uses the same header to size its status register count field.
- One natural sub-module: fifo_ram.
  - Parameters: AW and width 8.
  - One write port, one read port, read data registered one cycle after address, no reset.
  - Infers block or distributed RAM.
  - The control FSM (empty / head-only / buffering) stays in rs232in_fifo.

Test Plan:
1. Reset then single push 0xA5 at cycle 10 -> cycle 11: rd_valid=1, rd_data=0xA5, count=1. rd at cycle 12 -> cycle 13: rd_valid=0, count=0.
2. Push 0x00..0x0F on consecutive cycles (DEPTH=16) -> count=16. Push 0x10 -> dropped, overflow=1, count=16. Pops return 0x00..0x0F in order, one per cycle, with no gaps.
3. Full FIFO, push 0x55 with rd in the same cycle -> overflow stays 0, count=16, last popped byte is 0x55 after 15 further pops. This covers pointer wrap.
4. count=1 (head 0x11), simultaneous push 0x22 and rd -> next cycle rd_data=0x22, count=1. count=3 with push+pop -> count stays 3 and order is preserved.
5. Fill 5 bytes, assert flush together with in_valid=1 and rd=1 -> next cycle count=0, rd_valid=0, overflow unchanged. A subsequent push 0x77 appears at the head one cycle later.
6. overflow=1 and clr_overflow asserted in the same cycle as a full-drop -> overflow stays 1. Next cycle clr_overflow alone -> 0. Assert rst_n=0 asynchronously mid-burst (between edges) -> outputs go to 0 immediately.
